shift_arbiter: RTL and testbench
================================

# shift_arbiter

Round-robin arbiter and sequencer that shares one 8-bit logical right shifter among NREQ requesters. Each requester presents an operand and a 3-bit shift amount with a valid/ready handshake. The block grants one requester per cycle, performs the zero-fill right shift, and holds the result in a single-entry output register tagged with the requester index. It sits between the requesting datapath blocks and any consumer of shifted results, giving each requester bounded-latency access to the shared shift resource.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester-index width (derived; not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_data  in  NREQ*8  operands; requester i at [8i+7:8i]
- req_shift  in  NREQ*3  shift amounts; requester i at [3i+2:3i]
- rsp_valid  out  1  result register holds a valid result
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  8  shifted result
- rsp_id  out  IDW  index of the requester that produced rsp_data

## Operation
- Shift: rsp_data = {s zeros, data[7:s]} for s = 0..7. s=0 passes the operand through; s=7 yields {7'b0, data[7]}. No sign extension. No rotation.
- FSM, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1, and rsp_data/rsp_id are held stable.
- Accept condition, `can_acc`: state==EMPTY, or (state==FULL and rsp_ready). A same-cycle drain plus refill is allowed.
- Grant:
  - When can_acc and any req_valid is set, grant the first valid requester scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - req_ready[g]=1 for the granted index only; all other bits are 0.
  - When !can_acc, req_ready is all zero.
  - req_ready is combinational from req_valid, ptr, state and rsp_ready.
- On accept of requester g:
  - Result register ← shift(req_data[g], req_shift[g]).
  - rsp_id ← g.
  - State → FULL.
  - ptr ← (g+1) mod NREQ.
- ptr changes only on accept. Idle cycles and stalled cycles leave it unchanged.
- FULL with rsp_ready=1 and no valid requester: state → EMPTY. rsp_data/rsp_id keep their last value (don't-care).
- FULL with rsp_ready=0: hold everything; req_ready=0; no grant.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- Requesters must hold data/shift stable while valid and not ready. The block does not check this.

## Timing
- Reset values (async assert; deassert is synchronous to clk):
  - state=EMPTY
  - rsp_valid=0
  - rsp_data=8'h00
  - rsp_id=0
  - ptr=0
- Latency: request accepted in cycle N → rsp_valid=1 with the result in cycle N+1.
- Throughput: one result per cycle while rsp_ready stays high.
- Back-pressure is immediate: rsp_ready low in cycle N → req_ready all zero in cycle N.
- Reset mid-operation: any held result is discarded, rsp_valid drops asynchronously, and ptr returns to 0. In-flight requests are not accepted during reset and must be re-presented.
- Simultaneous drain and refill: the old result is consumed, the new result is visible the next cycle, and rsp_valid stays 1 with no bubble.
- Wrap-around: grant at index NREQ-1 sets ptr=0.

## Structure
- Shared package `shift_arb_pkg`:
  - state typedef {EMPTY, FULL}
  - constants DATA_W=8, SHAMT_W=3
- Sub-module `rr_grant`: combinational round-robin priority picker.
  - Inputs: NREQ-wide valid, ptr.
  - Outputs: one-hot grant, encoded index, any.
- The shift function is an inline combinational function in the top.
- The FSM, result register and ptr live in `shift_arbiter`.

## Test plan
- Reset then single request: req0 data=8'hB4, shift=3, rsp_ready=1 → next cycle rsp_valid=1, rsp_data=8'h16, rsp_id=0.
- Shift boundaries: data=8'hFF with shift=0 → 8'hFF; shift=7 → 8'h01. data=8'h80 with shift=7 → 8'h01. data=8'h7F with shift=7 → 8'h00.
- All 4 requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1…, one result per cycle.
- Back-pressure: FULL with rsp_ready=0 for 3 cycles → rsp_data/rsp_id stable, req_ready=0, ptr unchanged. rsp_ready=1 → drain and refill in the same cycle, no bubble.
- Fairness after idle: only req2 valid and granted (ptr=3). Then req1 and req3 valid → req3 granted first, then req1.
- Reset asserted while FULL → rsp_valid=0 immediately. After release, req1 and req0 valid → req0 granted (ptr=0).

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift_arbiter block.
package shift_arb_pkg;

    typedef enum logic {EMPTY, FULL} state_t;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first valid index scanning ptr, ptr+1, ... modulo NREQ.
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= NREQ) j = j - NREQ;
        return IDW'(j);
    endfunction

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && valid[wrap_idx(ptr, k)]) begin
                any                    = 1'b1;
                grant[wrap_idx(ptr, k)] = 1'b1;
                idx                    = wrap_idx(ptr, k);
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 8-bit zero-fill right shifter among NREQ requesters,
// with a single-entry tagged result register.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    input  logic [NREQ*SHAMT_W-1:0]   req_shift,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [IDW-1:0]            rsp_id
);

    function automatic logic [DATA_W-1:0] shr(input logic [DATA_W-1:0] d,
                                              input logic [SHAMT_W-1:0] s);
        return d >> s;
    endfunction

    state_t               state;
    logic [IDW-1:0]       ptr;
    logic [NREQ-1:0]      grant;
    logic [IDW-1:0]       grant_idx;
    logic                 grant_any;
    logic                 can_acc;
    logic                 accept;
    logic [DATA_W-1:0]    sel_data;
    logic [SHAMT_W-1:0]   sel_shift;

    rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr_grant (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // A full register can take a new result only in the cycle its current one drains.
    assign can_acc   = (state == EMPTY) || rsp_ready;
    assign accept    = can_acc && grant_any;
    assign req_ready = can_acc ? grant : '0;

    always_comb begin
        sel_data  = '0;
        sel_shift = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_data  = req_data[i*DATA_W +: DATA_W];
                sel_shift = req_shift[i*SHAMT_W +: SHAMT_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
            rsp_data  <= shr(sel_data, sel_shift);
            rsp_id    <= grant_idx;
            ptr       <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (state == FULL && rsp_ready) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter with hand-computed expected values.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [11:0] req_shift;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Table operands and their expected shifted results.
    logic [7:0] tab_data [4] = '{8'h81, 8'h42, 8'hF0, 8'hC3};
    logic [2:0] tab_shift[4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [7:0] tab_exp  [4] = '{8'h81, 8'h21, 8'h3C, 8'h18};

    shift_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shift (req_shift),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] s);
        req_data[i*8 +: 8]  = d;
        req_shift[i*3 +: 3] = s;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [7:0] d);
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".id"},    32'(rsp_id),    32'(id));
        check({tag, ".data"},  32'(rsp_data),  32'(d));
    endtask

    // Present a single request on requester i and check grant plus result.
    task automatic single(input string tag, input int i, input logic [7:0] d,
                          input logic [2:0] s, input logic [7:0] exp);
        req_valid = 4'b0001 << i;
        set_req(i, d, s);
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(4'b0001 << i));
        tick();
        check_rsp(tag, 2'(i), exp);
    endtask

    task automatic load_table();
        for (int i = 0; i < 4; i++) set_req(i, tab_data[i], tab_shift[i]);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_shift = '0;
        rsp_ready = 1'b1;
        #12;
        check("reset.valid", 32'(rsp_valid), 32'd0);
        check("reset.data",  32'(rsp_data),  32'd0);
        check("reset.id",    32'(rsp_id),    32'd0);
        tick();
        rst = 1'b0;

        // Basic request and shift boundaries; ptr walks 0 -> 1 -> 2 -> 3 -> 0 -> 1.
        single("basic",   0, 8'hB4, 3'd3, 8'h16);
        single("ff_s0",   1, 8'hFF, 3'd0, 8'hFF);
        single("ff_s7",   2, 8'hFF, 3'd7, 8'h01);
        single("80_s7",   3, 8'h80, 3'd7, 8'h01);
        single("7f_s7",   0, 8'h7F, 3'd7, 8'h00);

        req_valid = '0;
        tick();
        check("drain.valid", 32'(rsp_valid), 32'd0);

        // Wrap-around: a grant at index 3 must return ptr to 0.
        single("wrap", 3, 8'h40, 3'd1, 8'h20);

        // All requesters valid: grants rotate 0,1,2,3,0,1,2,3 with one result per cycle.
        load_table();
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("rr%0d.ready", c), 32'(req_ready), 32'(4'b0001 << (c % 4)));
            tick();
            check_rsp($sformatf("rr%0d", c), 2'(c % 4), tab_exp[c % 4]);
        end

        // Back-pressure while full: everything holds, ptr stays at 0.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d.ready", c), 32'(req_ready), 32'd0);
            tick();
            check_rsp($sformatf("bp%0d", c), 2'd3, 8'h18);
        end
        rsp_ready = 1'b1;
        #1;
        check("refill.ready", 32'(req_ready), 32'b0001);
        tick();
        check_rsp("refill", 2'd0, 8'h81);

        // Idle, then only req2 (ptr=1 -> req2 wins, ptr becomes 3).
        req_valid = '0;
        tick();
        check("idle.valid", 32'(rsp_valid), 32'd0);
        req_valid = 4'b0100;
        #1;
        check("fair2.ready", 32'(req_ready), 32'b0100);
        tick();
        check_rsp("fair2", 2'd2, 8'h3C);
        req_valid = 4'b1010;
        #1;
        check("fair3.ready", 32'(req_ready), 32'b1000);
        tick();
        check_rsp("fair3", 2'd3, 8'h18);
        req_valid = 4'b0010;
        #1;
        check("fair1.ready", 32'(req_ready), 32'b0010);
        tick();
        check_rsp("fair1", 2'd1, 8'h21);

        // Reset while full drops rsp_valid asynchronously and returns ptr to 0.
        req_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        check("rst_full.valid", 32'(rsp_valid), 32'd0);
        check("rst_full.data",  32'(rsp_data),  32'd0);
        tick();
        tick();
        rst = 1'b0;
        req_valid = 4'b0011;
        #1;
        check("post_rst.ready", 32'(req_ready), 32'b0001);
        tick();
        check_rsp("post_rst", 2'd0, 8'h81);

        req_valid = '0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
